seq_alu_mdu: RTL and testbench

- Execute stage that consumes ALUOperation from the ALU control decoder plus the two register-file operands.
- Produces a registered ALUResult and Zero flag.
- Single-cycle ops (AND/OR/NOR/ADD/SUB/INC/MOV) complete in one cycle.
- MULT/MULTPLUS run on an iterative 32-cycle shift-add multiplier into HI/LO. Stall is raised so the pipeline holds while the multiplier works.

---
 rtl/seq_alu_mdu_if.sv | 37 +++
 rtl/seq_alu_mdu.sv | 153 +++++++++++++++
 tb/tb_seq_alu_mdu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_mdu_if.sv
// rtl/seq_alu_mdu_if.sv - request/result bundle between the pipeline and the execute stage
//
// Signals:
//   start        request strobe, accepted when the stage is not busy
//   ALUOperation 4-bit opcode from the ALU control decoder
//   A, B         operands (rs, rt / extended immediate)
//   ALUResult    registered result
//   Zero         registered (ALUResult == 0)
//   busy         multiplier running, pipeline must stall
//   done         one-cycle pulse, result valid
//   HI, LO       upper/lower product registers
// Modports: master = pipeline side, slave = execute stage.

interface seq_alu_mdu_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [3:0]            ALUOperation;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic [DATA_WIDTH-1:0] ALUResult;
   logic                  Zero;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] HI;
   logic [DATA_WIDTH-1:0] LO;

   modport master (
      output start, ALUOperation, A, B,
      input  ALUResult, Zero, busy, done, HI, LO
   );

   modport slave (
      input  start, ALUOperation, A, B,
      output ALUResult, Zero, busy, done, HI, LO
   );
endinterface

// File: rtl/seq_alu_mdu.sv
// rtl/seq_alu_mdu.sv - execute stage: single-cycle ALU plus iterative shift-add multiplier into HI/LO
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low reset
//   bus    seq_alu_mdu_if.slave (start/ALUOperation/A/B in; ALUResult/Zero/busy/done/HI/LO out)
//
// Single-cycle ops load ALUResult at the accept edge and pulse done in the
// next cycle. MULT/MULTPLUS spend DATA_WIDTH cycles in MUL (busy=1), write
// HI/LO/ALUResult at the last step edge, then show done for one cycle in FIN.

module seq_alu_mdu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   seq_alu_mdu_if.slave  bus
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int PW = 2 * DATA_WIDTH;

   localparam logic [3:0] OP_AND      = 4'b0000;
   localparam logic [3:0] OP_OR       = 4'b0001;
   localparam logic [3:0] OP_NOR      = 4'b0010;
   localparam logic [3:0] OP_ADD      = 4'b0011;
   localparam logic [3:0] OP_SUB      = 4'b0100;
   localparam logic [3:0] OP_INC      = 4'b0101;
   localparam logic [3:0] OP_MULTPLUS = 4'b0110;
   localparam logic [3:0] OP_MOV      = 4'b0111;
   localparam logic [3:0] OP_MULT     = 4'b1000;
   localparam logic [3:0] OP_MFHI     = 4'b1010;
   localparam logic [3:0] OP_MFLO     = 4'b1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_zero;
   logic                  r_done_sc;
   logic [DATA_WIDTH-1:0] r_hi;
   logic [DATA_WIDTH-1:0] r_lo;
   logic [PW-1:0]         r_acc;
   logic [PW-1:0]         r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [CW-1:0]         r_cnt;

   logic                  w_is_mul;
   logic                  w_accept;
   logic                  w_last_step;
   logic [PW-1:0]         w_acc_next;
   logic [DATA_WIDTH-1:0] w_alu;

   assign w_is_mul    = (bus.ALUOperation == OP_MULT) || (bus.ALUOperation == OP_MULTPLUS);
   // FIN has busy=0, so a new request may be taken there as well as in IDLE.
   assign w_accept    = bus.start && (r_state != S_MUL);
   assign w_last_step = (r_cnt == CW'(DATA_WIDTH - 1));
   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_comb begin
      w_alu = '0;
      case (bus.ALUOperation)
         OP_AND:  w_alu = bus.A & bus.B;
         OP_OR:   w_alu = bus.A | bus.B;
         OP_NOR:  w_alu = ~(bus.A | bus.B);
         OP_ADD:  w_alu = bus.A + bus.B;
         OP_SUB:  w_alu = bus.A - bus.B;
         OP_INC:  w_alu = bus.A + DATA_WIDTH'(1);
         OP_MOV:  w_alu = bus.A;
         OP_MFHI: w_alu = r_hi;
         OP_MFLO: w_alu = r_lo;
         default: w_alu = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE,
         S_FIN:   w_state_next = (w_accept && w_is_mul) ? S_MUL : S_IDLE;
         S_MUL:   w_state_next = w_last_step ? S_FIN : S_MUL;
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.busy = (r_state == S_MUL);
      bus.done = (r_state == S_FIN) || r_done_sc;
   end

   // Datapath: result/flag registers and the shift-add multiplier
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_done_sc <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
      end else begin
         r_done_sc <= 1'b0;
         if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last_step) begin
               r_hi     <= w_acc_next[PW-1:DATA_WIDTH];
               r_lo     <= w_acc_next[DATA_WIDTH-1:0];
               r_result <= w_acc_next[DATA_WIDTH-1:0];
               r_zero   <= (w_acc_next[DATA_WIDTH-1:0] == '0);
            end
         end else if (w_accept) begin
            if (w_is_mul) begin
               // MULTPLUS seeds the accumulator with the current HI:LO.
               r_acc    <= (bus.ALUOperation == OP_MULTPLUS) ? {r_hi, r_lo} : '0;
               r_mcand  <= {{DATA_WIDTH{1'b0}}, bus.A};
               r_mplier <= bus.B;
               r_cnt    <= '0;
            end else begin
               r_result  <= w_alu;
               r_zero    <= (w_alu == '0);
               r_done_sc <= 1'b1;
            end
         end
      end
   end

   assign bus.ALUResult = r_result;
   assign bus.Zero      = r_zero;
   assign bus.HI        = r_hi;
   assign bus.LO        = r_lo;

endmodule

// File: tb/tb_seq_alu_mdu.sv
// tb/tb_seq_alu_mdu.sv - directed self-checking bench for seq_alu_mdu

module tb_seq_alu_mdu;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   seq_alu_mdu_if #(.DATA_WIDTH(32)) bus();

   seq_alu_mdu #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge; returns at the negedge after that edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      bus.start        = 1'b1;
      bus.ALUOperation = op;
      bus.A            = x;
      bus.B            = y;
      @(negedge clk);
      bus.start        = 1'b0;
   endtask

   // Issue a multiply and wait (bounded) for done; cyc = edges after accept.
   task automatic run_mul(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int cyc);
      issue(op, x, y);
      cyc = 0;
      while (!bus.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int busy_cnt;
      int done_cnt;
      logic hold_ok;

      checks = 0;
      errors = 0;

      // Reset held with a live request
      reset            = 1'b0;
      bus.start        = 1'b1;
      bus.ALUOperation = 4'b0011;
      bus.A            = 32'h1;
      bus.B            = 32'h2;
      @(negedge clk);
      @(negedge clk);
      chk("rst_result", bus.ALUResult, 32'h0);
      chk("rst_zero",   bus.Zero, 1'b0);
      chk("rst_busy",   bus.busy, 1'b0);
      chk("rst_done",   bus.done, 1'b0);
      chk("rst_hi",     bus.HI, 32'h0);
      chk("rst_lo",     bus.LO, 32'h0);
      bus.start = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      chk("post_rst_done", bus.done, 1'b0);

      // Single-cycle ops
      issue(4'b0011, 32'hFFFF_FFFF, 32'h1);
      chk("add_wrap_result", bus.ALUResult, 32'h0);
      chk("add_wrap_zero",   bus.Zero, 1'b1);
      chk("add_wrap_done",   bus.done, 1'b1);
      @(negedge clk);
      chk("add_done_clear",  bus.done, 1'b0);
      chk("add_hold",        bus.ALUResult, 32'h0);

      issue(4'b0100, 32'h5, 32'h5);
      chk("sub_zero",   bus.Zero, 1'b1);
      issue(4'b0010, 32'h0, 32'h0);
      chk("nor_result", bus.ALUResult, 32'hFFFF_FFFF);
      chk("nor_zero",   bus.Zero, 1'b0);
      chk("b2b_done",   bus.done, 1'b1);
      issue(4'b0101, 32'h7, 32'h0);
      chk("inc_result", bus.ALUResult, 32'h8);
      issue(4'b1100, 32'h5, 32'h5);
      chk("op1100_result", bus.ALUResult, 32'h0);
      chk("op1100_zero",   bus.Zero, 1'b1);
      issue(4'b1001, 32'h9, 32'h9);
      chk("op1001_result", bus.ALUResult, 32'h0);
      issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
      chk("and_result", bus.ALUResult, 32'h0000_F000);
      issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
      chk("or_result",  bus.ALUResult, 32'h0000_FFF0);

      // MULT with an ignored start pulse while busy
      issue(4'b1000, 32'hFFFF_FFFF, 32'h2);
      chk("mult_busy_start", bus.busy, 1'b1);
      chk("mult_no_done",    bus.done, 1'b0);
      cyc      = 0;
      busy_cnt = 0;
      hold_ok  = 1'b1;
      while (!bus.done && cyc < 40) begin
         if (bus.busy) busy_cnt++;
         if (bus.ALUResult !== 32'h0000_FFF0) hold_ok = 1'b0;
         bus.start        = (cyc == 9);
         bus.ALUOperation = 4'b0011;
         bus.A            = 32'h1;
         bus.B            = 32'h1;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      chk("mult_latency",   cyc, 32);
      chk("mult_busy_cyc",  busy_cnt, 32);
      chk("mult_hold",      hold_ok, 1'b1);
      chk("mult_fin_busy",  bus.busy, 1'b0);
      chk("mult_hi",        bus.HI, 32'h0000_0001);
      chk("mult_lo",        bus.LO, 32'hFFFF_FFFE);
      chk("mult_result",    bus.ALUResult, 32'hFFFF_FFFE);
      chk("mult_zero",      bus.Zero, 1'b0);

      // MFLO at FIN, then MFHI
      issue(4'b1011, 32'h0, 32'h0);
      chk("mflo_result", bus.ALUResult, 32'hFFFF_FFFE);
      chk("mflo_done",   bus.done, 1'b1);
      @(negedge clk);
      chk("no_extra_done", bus.done, 1'b0);
      issue(4'b1010, 32'h0, 32'h0);
      chk("mfhi_result", bus.ALUResult, 32'h0000_0001);

      // MULTPLUS accumulate
      run_mul(4'b0110, 32'h3, 32'h1, cyc);
      chk("mplus_latency", cyc, 32);
      chk("mplus_hi",     bus.HI, 32'h2);
      chk("mplus_lo",     bus.LO, 32'h1);
      chk("mplus_result", bus.ALUResult, 32'h1);

      // Build HI:LO = all ones, then wrap to zero
      run_mul(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      chk("sq_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
      run_mul(4'b0110, 32'hFFFF_FFFF, 32'h2, cyc);
      chk("ones_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFF);
      run_mul(4'b0110, 32'h1, 32'h1, cyc);
      chk("wrap_hilo",   {bus.HI, bus.LO}, 64'h0);
      chk("wrap_result", bus.ALUResult, 32'h0);
      chk("wrap_zero",   bus.Zero, 1'b1);

      // Reset mid-multiply
      run_mul(4'b1000, 32'h5, 32'h7, cyc);
      chk("m57_lo", bus.LO, 32'd35);
      @(negedge clk);
      issue(4'b1000, 32'h3, 32'h3);
      repeat (14) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy",   bus.busy, 1'b0);
      chk("abort_done",   bus.done, 1'b0);
      chk("abort_hi",     bus.HI, 32'h0);
      chk("abort_lo",     bus.LO, 32'h0);
      chk("abort_result", bus.ALUResult, 32'h0);
      reset    = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);

      issue(4'b0111, 32'h0000_1234, 32'h0);
      chk("mov_result", bus.ALUResult, 32'h0000_1234);
      chk("mov_done",   bus.done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
